fm_stream_source: RTL and testbench
===================================

# fm_stream_source

Feature-map source and result sink for the `PE` → `relu` convolution chain. It holds one FM_SIZE×FM_SIZE feature map loaded over a write port and streams it into `PE` as a raster-order `i_en`/`i_DataFM` stream. It counts and stores the `relu` results, and stops the stream once enough results have been counted. This is the hardware counterpart to the stimulus and collection logic that currently lives only in simulation.

## Interface
Parameters:
- KERNEL_SIZE, 3, kernel edge length; must match `PE`
- FM_SIZE, 5, input feature-map edge length; must match `PE`
- PADDING, 0, padding; must match `PE`
- STRIDE, 1, stride; must match `PE`
- Derived (localparam, not overridable):
  - OUT_SIZE = (FM_SIZE-KERNEL_SIZE+2*PADDING)/STRIDE+1
  - FM_N = FM_SIZE**2
  - OUT_N = OUT_SIZE**2

Ports:
- i_clk  in  1  the single clock
- i_rst  in  1  reset, synchronous, active-high
- i_wr_en  in  1  feature-map load strobe
- i_wr_addr  in  $clog2(FM_N)  raster address of the pixel being loaded
- i_wr_data  in  30  signed pixel
- i_start  in  1  begin streaming; single-cycle pulse
- o_en  out  1  stream valid; drives `PE.i_en`
- o_DataFM  out  30  signed pixel; drives `PE.i_DataFM`
- i_res_en  in  1  result valid; from `relu.o_en`
- i_res_data  in  48  signed result; from `relu.o_data`
- i_rd_addr  in  $clog2(OUT_N)  result buffer read address
- o_rd_data  out  48  result buffer read data
- o_res_cnt  out  $clog2(OUT_N)+1  number of results captured
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when a run completes

## Operation
- Storage:
  - FM buffer: FM_N × 30 bits.
  - Result buffer: OUT_N × 48 bits.
  - Neither buffer is reset.
- Loading:
  - `i_wr_en` writes only in IDLE.
  - Writes in any other state are ignored.
- Stop count: STOP_CNT = OUT_N when FM_SIZE==KERNEL_SIZE, otherwise OUT_N-1. The one-cycle lead in the second case compensates for the registered decision.
- State machine:
  - IDLE:
    - o_en=0.
    - `i_start` clears o_res_cnt and the pixel index, then goes to STREAM.
  - STREAM:
    - o_en=1; o_DataFM = FM[idx]; idx increments each cycle.
    - After idx FM_N-1 is presented, go to FLUSH.
  - FLUSH:
    - o_en=1, o_DataFM=0.
    - Keeps the `PE` pipeline advancing until the stop condition.
  - Stop condition: in STREAM or FLUSH, when o_res_cnt==STOP_CNT, the next cycle goes to DRAIN with o_en=0. This takes priority over the idx advance.
  - DRAIN: o_en=0; wait until o_res_cnt==OUT_N, then go to DONE.
  - DONE: o_done=1 for one cycle, then go to IDLE.
- Result capture:
  - In STREAM, FLUSH or DRAIN, each `i_res_en` cycle with o_res_cnt<OUT_N writes `i_res_data` to RES[o_res_cnt] and increments o_res_cnt.
  - Results arriving when o_res_cnt==OUT_N, or arriving in IDLE or DONE, are dropped.
- Data is passed through unchanged:
  - No sign handling beyond storage width.
  - Negative pixels stream as their 30-bit two's complement value.
- `i_start` outside IDLE is ignored.
- o_res_cnt holds its value in IDLE after a run, so software can read it.
- Reset mid-run:
  - Return to IDLE at the next edge: o_en=0, o_done=0, o_busy=0, o_res_cnt=0.
  - Buffer contents are preserved.

## Timing
- Reset values:
  - o_en=0, o_DataFM=0, o_res_cnt=0, o_busy=0, o_done=0, o_rd_data=0.
  - State is IDLE.
- All outputs are registered.
- Stream start: with `i_start` high at edge t, o_en=1 and o_DataFM=FM[0] are valid after edge t+1. FM[k] is valid after edge t+1+k, on consecutive cycles with no bubbles.
- Stop latency: the edge at which o_res_cnt becomes STOP_CNT is followed, one edge later, by o_en=0.
- Capture: `i_res_en` is sampled at edge e; o_res_cnt reflects the increment after edge e.
- o_done is asserted the cycle after o_res_cnt reaches OUT_N, provided the state is already DRAIN.
- Read port: o_rd_data = RES[i_rd_addr] one cycle after the address is presented, in any state.
- Write/read of the same result address in the same cycle returns the old data.

## Test plan
- FM_SIZE=2, KERNEL_SIZE=1, PE+relu with weight 1:
  - Load 1, 2, -10, 4; start.
  - Required: o_DataFM sequence 1, 2, -10, 4 on consecutive cycles.
  - Required: RES = 1, 2, 0, 4; o_res_cnt=4; one o_done pulse; o_en drops before any pixel repeats.
- FM_SIZE=KERNEL_SIZE=2, bench-driven `i_res_en`:
  - Single result returned.
  - Required: o_en falls one edge after o_res_cnt=1; o_done is asserted the cycle after.
- FM_SIZE=5, KERNEL_SIZE=3:
  - Load pixels 1..25; bench returns 9 results, each 2 cycles apart, starting 12 cycles after start.
  - Required: FLUSH zeros appear after pixel 25 if results lag; o_en falls after the 8th result; o_res_cnt ends at 9.
- Extra result: a 10th `i_res_en` after o_res_cnt=9 leaves o_res_cnt=9 and RES[8] unchanged.
- Ignored inputs during STREAM:
  - Writing FM[0]=99 leaves the buffer unchanged; the next run streams the original FM[0].
  - A second `i_start` has no effect.
- Reset mid-run: `i_rst` during FLUSH gives o_en=0, o_res_cnt=0, o_busy=0 next cycle; a new `i_start` restarts cleanly from FM[0].

Source files
------------

// File: rtl/fm_stream_source.sv
// Feature-map source and result sink for the PE -> relu chain. It streams a stored
// feature map into PE and captures relu results until a full output map has arrived.
module fm_stream_source #(
   parameter int KERNEL_SIZE = 3,
   parameter int FM_SIZE     = 5,
   parameter int PADDING     = 0,
   parameter int STRIDE      = 1,
   localparam int OUT_SIZE   = (FM_SIZE - KERNEL_SIZE + 2*PADDING)/STRIDE + 1,
   localparam int FM_N       = FM_SIZE**2,
   localparam int OUT_N      = OUT_SIZE**2,
   // Address widths floor at 1 bit so a single-entry buffer still has a legal port.
   localparam int FAW        = (FM_N > 1) ? $clog2(FM_N) : 1,
   localparam int RAW        = (OUT_N > 1) ? $clog2(OUT_N) : 1,
   localparam int CW         = $clog2(OUT_N) + 1
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_wr_en,
   input  logic [FAW-1:0] i_wr_addr,
   input  logic [29:0]    i_wr_data,
   input  logic           i_start,
   output logic           o_en,
   output logic [29:0]    o_DataFM,
   input  logic           i_res_en,
   input  logic [47:0]    i_res_data,
   input  logic [RAW-1:0] i_rd_addr,
   output logic [47:0]    o_rd_data,
   output logic [CW-1:0]  o_res_cnt,
   output logic           o_busy,
   output logic           o_done
);

   // The stop decision is registered, so when PE emits results while pixels are
   // still flowing it is taken one result early.
   localparam int STOP_CNT = (FM_SIZE == KERNEL_SIZE) ? OUT_N : OUT_N - 1;

   localparam logic [FAW-1:0] LAST_IDX = FAW'(FM_N - 1);
   localparam logic [CW-1:0]  STOP_C   = CW'(STOP_CNT);
   localparam logic [CW-1:0]  FULL_C   = CW'(OUT_N);
   localparam logic [FAW:0]   FM_N_C   = (FAW+1)'(FM_N);
   localparam logic [RAW:0]   OUT_N_C  = (RAW+1)'(OUT_N);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_FLUSH,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t          r_state;
   logic [FAW-1:0]  r_idx;
   logic [CW-1:0]   r_res_cnt;
   logic            r_en;
   logic [29:0]     r_data;
   logic            r_busy;
   logic            r_done;
   logic [47:0]     r_rd_data;

   logic [29:0]     r_fm  [FM_N];
   logic [47:0]     r_res [OUT_N];

   logic            w_active;
   logic            w_capture;
   logic            w_fm_wr;
   logic [RAW-1:0]  w_res_waddr;

   assign w_active    = (r_state == S_STREAM) || (r_state == S_FLUSH) || (r_state == S_DRAIN);
   assign w_capture   = w_active && i_res_en && (r_res_cnt < FULL_C);
   assign w_fm_wr     = (r_state == S_IDLE) && i_wr_en && ({1'b0, i_wr_addr} < FM_N_C);
   assign w_res_waddr = r_res_cnt[RAW-1:0];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_res_cnt <= '0;
         r_en      <= 1'b0;
         r_data    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_capture) r_res_cnt <= r_res_cnt + 1'b1;
         case (r_state)
            S_IDLE: begin
               r_en   <= 1'b0;
               r_data <= '0;
               if (i_start) begin
                  r_res_cnt <= '0;
                  r_idx     <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= S_STREAM;
               end
            end
            S_STREAM, S_FLUSH: begin
               if (r_res_cnt >= STOP_C) begin
                  r_en    <= 1'b0;
                  r_data  <= '0;
                  r_state <= S_DRAIN;
               end else begin
                  r_en <= 1'b1;
                  if (r_state == S_STREAM) begin
                     r_data <= r_fm[r_idx];
                     r_idx  <= r_idx + 1'b1;
                     if (r_idx == LAST_IDX) r_state <= S_FLUSH;
                  end else begin
                     r_data <= '0;
                  end
               end
            end
            S_DRAIN: begin
               r_en   <= 1'b0;
               r_data <= '0;
               if (r_res_cnt == FULL_C) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_en    <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Buffers are never cleared so a reset leaves loaded pixels and results readable.
   always_ff @(posedge i_clk) begin
      if (!i_rst && w_fm_wr)   r_fm[i_wr_addr]    <= i_wr_data;
      if (!i_rst && w_capture) r_res[w_res_waddr] <= i_res_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)                              r_rd_data <= '0;
      else if ({1'b0, i_rd_addr} < OUT_N_C)   r_rd_data <= r_res[i_rd_addr];
      else                                    r_rd_data <= '0;
   end

   assign o_en      = r_en;
   assign o_DataFM  = r_data;
   assign o_rd_data = r_rd_data;
   assign o_res_cnt = r_res_cnt;
   assign o_busy    = r_busy;
   assign o_done    = r_done;

endmodule

// File: tb/tb_fm_stream_source.sv
// Directed bench for fm_stream_source: three instances (2x2/k1, 2x2/k2, 5x5/k3) with
// a bench-side PE/relu model or directed results, checked against expected queues.
module tb_fm_stream_source;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   int checks = 0;
   int errors = 0;

   logic [29:0] pix_q[$];
   logic [47:0] exp_q[$];

   // Instance A: FM_SIZE=2, KERNEL_SIZE=1
   logic        a_wr_en, a_start, a_en, a_res_en, a_busy, a_done;
   logic [1:0]  a_wr_addr, a_rd_addr;
   logic [29:0] a_wr_data, a_data;
   logic [47:0] a_res_data, a_rd_data;
   logic [2:0]  a_cnt;

   // Instance B: FM_SIZE=2, KERNEL_SIZE=2
   logic        b_wr_en, b_start, b_en, b_res_en, b_busy, b_done;
   logic [1:0]  b_wr_addr;
   logic [0:0]  b_rd_addr;
   logic [29:0] b_wr_data, b_data;
   logic [47:0] b_res_data, b_rd_data;
   logic [0:0]  b_cnt;

   // Instance C: FM_SIZE=5, KERNEL_SIZE=3
   logic        c_wr_en, c_start, c_en, c_res_en, c_busy, c_done;
   logic [4:0]  c_wr_addr;
   logic [3:0]  c_rd_addr;
   logic [29:0] c_wr_data, c_data;
   logic [47:0] c_res_data, c_rd_data;
   logic [4:0]  c_cnt;

   fm_stream_source #(.KERNEL_SIZE(1), .FM_SIZE(2), .PADDING(0), .STRIDE(1)) u_a (
      .i_clk(clk), .i_rst(rst), .i_wr_en(a_wr_en), .i_wr_addr(a_wr_addr), .i_wr_data(a_wr_data),
      .i_start(a_start), .o_en(a_en), .o_DataFM(a_data), .i_res_en(a_res_en),
      .i_res_data(a_res_data), .i_rd_addr(a_rd_addr), .o_rd_data(a_rd_data),
      .o_res_cnt(a_cnt), .o_busy(a_busy), .o_done(a_done));

   fm_stream_source #(.KERNEL_SIZE(2), .FM_SIZE(2), .PADDING(0), .STRIDE(1)) u_b (
      .i_clk(clk), .i_rst(rst), .i_wr_en(b_wr_en), .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data),
      .i_start(b_start), .o_en(b_en), .o_DataFM(b_data), .i_res_en(b_res_en),
      .i_res_data(b_res_data), .i_rd_addr(b_rd_addr), .o_rd_data(b_rd_data),
      .o_res_cnt(b_cnt), .o_busy(b_busy), .o_done(b_done));

   fm_stream_source #(.KERNEL_SIZE(3), .FM_SIZE(5), .PADDING(0), .STRIDE(1)) u_c (
      .i_clk(clk), .i_rst(rst), .i_wr_en(c_wr_en), .i_wr_addr(c_wr_addr), .i_wr_data(c_wr_data),
      .i_start(c_start), .o_en(c_en), .o_DataFM(c_data), .i_res_en(c_res_en),
      .i_res_data(c_res_data), .i_rd_addr(c_rd_addr), .o_rd_data(c_rd_data),
      .o_res_cnt(c_cnt), .o_busy(c_busy), .o_done(c_done));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [47:0] relu30(input logic [29:0] d);
      return d[29] ? 48'd0 : {18'd0, d};
   endfunction

   function automatic logic [47:0] c_val(input int j);
      return (j == 4) ? 48'hFFFF_FFFF_FFF0 : 48'(1000 + j);
   endfunction

   int          n_en, n_done, seen, j, n_first, n_full;
   logic [29:0] exp_pix;
   logic [29:0] a_pix [4];
   logic        en_h   [48];
   logic        done_h [48];

   initial begin
      rst = 1'b1;
      a_wr_en = 0; a_wr_addr = '0; a_wr_data = '0; a_start = 0; a_res_en = 0; a_res_data = '0; a_rd_addr = '0;
      b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0; b_start = 0; b_res_en = 0; b_res_data = '0; b_rd_addr = '0;
      c_wr_en = 0; c_wr_addr = '0; c_wr_data = '0; c_start = 0; c_res_en = 0; c_res_data = '0; c_rd_addr = '0;
      repeat (3) tick();

      // ---------------- reset state ----------------
      chk("rst_c_en", 48'(c_en), 48'd0);
      chk("rst_c_data", 48'(c_data), 48'd0);
      chk("rst_c_cnt", 48'(c_cnt), 48'd0);
      chk("rst_c_busy", 48'(c_busy), 48'd0);
      chk("rst_c_done", 48'(c_done), 48'd0);
      chk("rst_c_rd", c_rd_data, 48'd0);
      chk("rst_a_en", 48'(a_en), 48'd0);
      chk("rst_b_busy", 48'(b_busy), 48'd0);
      rst = 1'b0;
      tick();

      // ---------------- A: 2x2, k=1, bench PE+relu with weight 1 ----------------
      a_pix[0] = 30'd1; a_pix[1] = 30'd2; a_pix[2] = 30'h3FFF_FFF6; a_pix[3] = 30'd4;
      for (int i = 0; i < 4; i++) begin
         a_wr_en = 1; a_wr_addr = 2'(i); a_wr_data = a_pix[i];
         pix_q.push_back(a_pix[i]);
         tick();
      end
      a_wr_en = 0;
      a_start = 1; tick(); a_start = 0;
      n_en = 0; n_done = 0; seen = 0;
      for (int n = 0; n < 20; n++) begin
         a_res_en = 0;
         if (a_en) begin
            exp_pix = (pix_q.size() > 0) ? pix_q.pop_front() : 30'd0;
            chk("a_stream", 48'(a_data), 48'(exp_pix));
            n_en++;
            if (seen < 4) begin
               a_res_en = 1; a_res_data = relu30(a_data);
               exp_q.push_back(relu30(exp_pix));
               seen++;
            end
         end
         if (a_done) n_done++;
         tick();
      end
      a_res_en = 0;
      chk("a_en_cycles", 48'(n_en), 48'd4);
      chk("a_cnt", 48'(a_cnt), 48'd4);
      chk("a_done_pulses", 48'(n_done), 48'd1);
      chk("a_busy_end", 48'(a_busy), 48'd0);
      for (int i = 0; i < 4; i++) begin
         a_rd_addr = 2'(i); tick();
         chk("a_res", a_rd_data, exp_q.pop_front());
      end

      // ---------------- B: 2x2, k=2, one directed result ----------------
      for (int i = 0; i < 4; i++) begin
         b_wr_en = 1; b_wr_addr = 2'(i); b_wr_data = 30'(5 + i);
         tick();
      end
      b_wr_en = 0;
      b_start = 1; tick(); b_start = 0;
      n_first = -1;
      for (int n = 0; n < 12; n++) begin
         en_h[n] = b_en; done_h[n] = b_done;
         if (b_cnt == 1'b1 && n_first < 0) n_first = n;
         b_res_en = 0;
         if (n == 3) begin
            b_res_en = 1; b_res_data = 48'h1234_5678_9ABC;
            exp_q.push_back(48'h1234_5678_9ABC);
         end
         tick();
      end
      b_res_en = 0;
      chk("b_cnt_edge", 48'(n_first), 48'd4);
      if (n_first < 0 || n_first > 8) n_first = 0;
      chk("b_en_at_cnt", 48'(en_h[n_first]), 48'd1);
      chk("b_en_fall", 48'(en_h[n_first+1]), 48'd0);
      chk("b_done_early", 48'(done_h[n_first+1]), 48'd0);
      chk("b_done_pulse", 48'(done_h[n_first+2]), 48'd1);
      chk("b_done_end", 48'(done_h[n_first+3]), 48'd0);
      b_rd_addr = 1'b0; tick();
      chk("b_res", b_rd_data, exp_q.pop_front());

      // ---------------- C run 1: 5x5, k=3, 9 results 2 cycles apart ----------------
      for (int i = 0; i < 25; i++) begin
         c_wr_en = 1; c_wr_addr = 5'(i); c_wr_data = 30'(i + 1);
         pix_q.push_back(30'(i + 1));
         tick();
      end
      c_wr_en = 0;
      c_start = 1; tick(); c_start = 0;
      chk("c1_busy_start", 48'(c_busy), 48'd1);
      chk("c1_en_start", 48'(c_en), 48'd0);
      n_en = 0; n_done = 0; j = 0; n_first = -1; n_full = -1;
      for (int n = 0; n < 40; n++) begin
         en_h[n] = c_en; done_h[n] = c_done;
         if (c_en) begin
            exp_pix = (pix_q.size() > 0) ? pix_q.pop_front() : 30'd0;
            chk("c1_stream", 48'(c_data), 48'(exp_pix));
            n_en++;
         end
         if (c_done) n_done++;
         if (c_cnt == 5'd8 && n_first < 0) n_first = n;
         if (c_cnt == 5'd9 && n_full < 0) n_full = n;
         c_res_en = 0;
         if (n >= 12 && ((n - 12) % 2 == 0) && j < 9) begin
            c_res_en = 1; c_res_data = c_val(j);
            exp_q.push_back(c_val(j));
            j++;
         end else if (n == 29) begin
            c_res_en = 1; c_res_data = 48'hDEAD_BEEF_0000;
         end
         tick();
      end
      c_res_en = 0;
      // 25 pixels on cycles 1..25, then FLUSH zeros until the cycle after count 8 (cycle 27).
      chk("c1_en_cycles", 48'(n_en), 48'd27);
      chk("c1_pix_left", 48'(pix_q.size()), 48'd0);
      chk("c1_cnt8_cycle", 48'(n_first), 48'd27);
      if (n_first < 0 || n_first > 40) n_first = 0;
      chk("c1_en_at_stop", 48'(en_h[n_first]), 48'd1);
      chk("c1_en_fall", 48'(en_h[n_first+1]), 48'd0);
      chk("c1_cnt9_cycle", 48'(n_full), 48'd29);
      if (n_full < 0 || n_full > 40) n_full = 0;
      chk("c1_done_pos", 48'(done_h[n_full+1]), 48'd1);
      chk("c1_done_pulses", 48'(n_done), 48'd1);
      chk("c1_cnt_hold", 48'(c_cnt), 48'd9);
      chk("c1_busy_end", 48'(c_busy), 48'd0);
      for (int i = 0; i < 9; i++) begin
         c_rd_addr = 4'(i); tick();
         chk("c1_res", c_rd_data, exp_q.pop_front());
      end

      // ---------------- C run 2: ignored write/start in STREAM, reset in FLUSH ----------------
      for (int i = 0; i < 25; i++) pix_q.push_back(30'(i + 1));
      c_start = 1; tick(); c_start = 0;
      chk("c2_cnt_cleared", 48'(c_cnt), 48'd0);
      for (int n = 0; n < 28; n++) begin
         if (c_en) begin
            exp_pix = (pix_q.size() > 0) ? pix_q.pop_front() : 30'd0;
            chk("c2_stream", 48'(c_data), 48'(exp_pix));
         end
         c_wr_en = (n == 2); c_wr_addr = '0; c_wr_data = 30'd99;
         c_start = (n == 2);
         c_res_en = (n == 5 || n == 7 || n == 9);
         c_res_data = 48'(32'h500 + n);
         rst = (n == 27);
         tick();
      end
      c_wr_en = 0; c_start = 0; c_res_en = 0;
      chk("c2_rst_en", 48'(c_en), 48'd0);
      chk("c2_rst_cnt", 48'(c_cnt), 48'd0);
      chk("c2_rst_busy", 48'(c_busy), 48'd0);
      chk("c2_rst_done", 48'(c_done), 48'd0);
      rst = 0;
      pix_q.delete();
      c_rd_addr = 4'd0; tick();
      chk("c2_res0_kept", c_rd_data, 48'h505);
      c_rd_addr = 4'd3; tick();
      chk("c2_res3_kept", c_rd_data, c_val(3));

      // ---------------- C run 3: clean restart from original FM[0] ----------------
      for (int i = 0; i < 5; i++) pix_q.push_back(30'(i + 1));
      c_start = 1; tick(); c_start = 0;
      for (int n = 0; n < 6; n++) begin
         if (c_en) begin
            exp_pix = (pix_q.size() > 0) ? pix_q.pop_front() : 30'd0;
            chk("c3_stream", 48'(c_data), 48'(exp_pix));
         end
         tick();
      end
      chk("c3_pix_left", 48'(pix_q.size()), 48'd0);
      rst = 1; tick(); rst = 0; tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
